// File: rtl/mm_accel_pkg.sv
// Shared definitions for the matrix-multiply accelerator datapath: bank
// polarity (tied to the 2:1 mux select) and operand-bank status encoding.
package mm_accel_pkg;

  localparam logic BANK_A = 1'b1;
  localparam logic BANK_B = 1'b0;

  localparam int DATA_W_DEF = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } bank_status_e;

endpackage

// File: rtl/pingpong_operand_buf_bank.sv
// One operand bank: DEPTH x DATA_W registers with a synchronous write port,
// a combinational read port and a synchronous clear on reset.
module operand_bank #(
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Next storage contents: single-entry update on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage registers, cleared to zero on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pingpong_operand_buf.sv
// Double-buffered operand store feeding the 2:1 memory mux: the loader fills
// one bank while the compute side drains the other; roles swap on fill/drain.
module pingpong_operand_buf
  import mm_accel_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic [DATA_W-1:0] bank_a_q,
  output logic [DATA_W-1:0] bank_b_q,
  output logic              mux_sel,
  output logic [AW-1:0]     rd_addr
);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  bank_status_e  status_a_q, status_a_d;
  bank_status_e  status_b_q, status_b_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  bank_status_e wr_status_s;
  bank_status_e rd_status_s;
  logic         wr_fire_s, rd_fire_s;
  logic         wr_done_s, rd_done_s;
  logic         we_a_s, we_b_s;

  assign wr_status_s = (wr_bank_q == BANK_A) ? status_a_q : status_b_q;
  assign rd_status_s = (rd_bank_q == BANK_A) ? status_a_q : status_b_q;

  assign wr_ready  = (wr_status_s == ST_EMPTY);
  assign rd_valid  = (rd_status_s == ST_FULL);
  assign rd_last   = rd_valid && (rd_ptr_q == PTR_LAST);
  assign wr_fire_s = wr_valid && wr_ready;
  assign rd_fire_s = rd_valid && rd_ready;
  assign wr_done_s = wr_fire_s && (wr_ptr_q == PTR_LAST);
  assign rd_done_s = rd_fire_s && rd_last;
  assign we_a_s    = wr_fire_s && (wr_bank_q == BANK_A);
  assign we_b_s    = wr_fire_s && (wr_bank_q == BANK_B);

  assign mux_sel = rd_bank_q;
  assign rd_addr = rd_ptr_q;

  // Status, pointer and bank-role updates. A fill and a drain finishing in the
  // same cycle always target different banks, so both apply independently.
  always_comb begin
    status_a_d = status_a_q;
    status_b_d = status_b_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (wr_done_s && (wr_bank_q == BANK_A)) begin
      status_a_d = ST_FULL;
    end else if (rd_done_s && (rd_bank_q == BANK_A)) begin
      status_a_d = ST_EMPTY;
    end else begin
      status_a_d = status_a_q;
    end

    if (wr_done_s && (wr_bank_q == BANK_B)) begin
      status_b_d = ST_FULL;
    end else if (rd_done_s && (rd_bank_q == BANK_B)) begin
      status_b_d = ST_EMPTY;
    end else begin
      status_b_d = status_b_q;
    end

    if (wr_done_s) begin
      wr_ptr_d  = '0;
      wr_bank_d = ~wr_bank_q;
    end else if (wr_fire_s) begin
      wr_ptr_d  = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d  = wr_ptr_q;
    end

    if (rd_done_s) begin
      rd_ptr_d  = '0;
      rd_bank_d = ~rd_bank_q;
    end else if (rd_fire_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d  = rd_ptr_q;
    end
  end

  // Control state registers; reset discards any partial fill or drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_a_q <= ST_EMPTY;
      status_b_q <= ST_EMPTY;
      wr_bank_q  <= BANK_A;
      rd_bank_q  <= BANK_A;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      status_a_q <= status_a_d;
      status_b_q <= status_b_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  operand_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank_a (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_a_s),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (bank_a_q)
  );

  operand_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank_b (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_b_s),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (bank_b_q)
  );

endmodule
